seven_bcd_capture: RTL and testbench

Seven-segment-to-BCD capture block: the receiving end of the multiplexed display interface driven by the microwave's BCD-to-seven-segment path. It samples the segment bus together with the one-hot digit select, decodes each stable pattern back to BCD, and assembles a full frame of digits. Each completed frame is presented as one registered word with a one-cycle valid strobe. It is used as a display readback monitor and as a loopback checker in the microwave design.

---
 rtl/seven_bcd_capture_if.sv | 29 ++
 rtl/seven_bcd_capture.sv | 142 ++++++++++++++
 tb/tb_seven_bcd_capture.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/seven_bcd_capture_if.sv
// Display-side bundle for the seven-segment capture block: the sampled
// segment bus and digit select, plus the reassembled frame and its strobes.
interface seven_bcd_capture_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seven;
  logic [DIGITS-1:0]   dsel;
  logic [4*DIGITS-1:0] bcd_out;
  logic                valid;
  logic                err;

  // Display driver / stimulus side
  modport master (
    output seven,
    output dsel,
    input  bcd_out,
    input  valid,
    input  err
  );

  // Capture block side
  modport slave (
    input  seven,
    input  dsel,
    output bcd_out,
    output valid,
    output err
  );
endinterface

// File: rtl/seven_bcd_capture.sv
// Seven-segment to BCD capture: filters the multiplexed segment bus for
// STABLE identical samples, decodes each committed digit, and emits a
// registered frame with a one-cycle valid strobe once every digit is seen.
// Optional macro SEVEN_BCD_BLANK_EN: all-dark pattern decodes to 4'hF.
module seven_bcd_capture #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input logic                  clk,
  input logic                  rst,
  seven_bcd_capture_if.slave   bus
);

  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(STABLE);

  logic [DIGITS-1:0]   prev_sel_q, prev_sel_d;
  logic [6:0]          prev_seg_q, prev_seg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic                onehot;
  logic                same;
  logic                commit;
  logic [4:0]          dec;
  logic [DIGITS-1:0]   seen_new;
  logic [4*DIGITS-1:0] shadow_new;

  // Returns {ok, code}; ok=0 marks a pattern that is not a digit.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0_0000;
    case (seg)
      7'b0111111: r = 5'b1_0000;
      7'b0000110: r = 5'b1_0001;
      7'b1011011: r = 5'b1_0010;
      7'b1001111: r = 5'b1_0011;
      7'b1100110: r = 5'b1_0100;
      7'b1101101: r = 5'b1_0101;
      7'b1111101: r = 5'b1_0110;
      7'b0000111: r = 5'b1_0111;
      7'b1111111: r = 5'b1_1000;
      7'b1101111: r = 5'b1_1001;
`ifdef SEVEN_BCD_BLANK_EN
      7'b0000000: r = 5'b1_1111;
`else
      7'b0000000: r = 5'b0_0000;
`endif
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Sample qualification: select shape, repeat detection and the single
  // cycle where the stability count first reaches its top.
  always_comb begin
    onehot = (bus.dsel != '0) && ((bus.dsel & (bus.dsel - DIGITS'(1))) == '0);
    same   = (bus.dsel == prev_sel_q) && (bus.seven == prev_seg_q);
    dec    = decode(bus.seven);
    commit = onehot && (same ? (cnt_q == CNT_TOP - CW'(1)) : (STABLE == 1));
  end

  // Next-state: stability counter, per-digit shadow, frame assembly.
  always_comb begin
    prev_sel_d = prev_sel_q;
    prev_seg_d = prev_seg_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    seen_d     = seen_q;
    bcd_d      = bcd_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    seen_new   = seen_q | bus.dsel;
    shadow_new = shadow_q;
    for (int j = 0; j < DIGITS; j++) begin
      if (bus.dsel[j]) shadow_new[4*j +: 4] = dec[3:0];
    end

    if (bus.dsel == '0) begin
      cnt_d      = '0;
      prev_sel_d = '0;
    end else if (!onehot) begin
      err_d      = 1'b1;
      cnt_d      = '0;
      prev_sel_d = '0;
    end else begin
      if (same) begin
        if (cnt_q != CNT_TOP) cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d      = CW'(1);
        prev_sel_d = bus.dsel;
        prev_seg_d = bus.seven;
      end
      if (commit) begin
        if (dec[4]) begin
          shadow_d = shadow_new;
          if (&seen_new) begin
            bcd_d   = shadow_new;
            valid_d = 1'b1;
            seen_d  = '0;
          end else begin
            seen_d = seen_new;
          end
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_sel_q <= '0;
      prev_seg_q <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      seen_q     <= '0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_sel_q <= prev_sel_d;
      prev_seg_q <= prev_seg_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      seen_q     <= seen_d;
      bcd_q      <= bcd_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.bcd_out = bcd_q;
  assign bus.valid   = valid_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_seven_bcd_capture.sv
// Directed bench for seven_bcd_capture with DIGITS=4, STABLE=3.
module tb_seven_bcd_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   valid_seen = 0;
  int   err_seen = 0;
  int   both_seen = 0;

  seven_bcd_capture_if #(.DIGITS(4)) bus ();

  seven_bcd_capture #(.DIGITS(4), .STABLE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, let the edge pass, observe 1 time unit later.
  task automatic step(input logic [3:0] d, input logic [6:0] s);
    bus.dsel  = d;
    bus.seven = s;
    @(posedge clk);
    #1;
    if (bus.valid === 1'b1) valid_seen++;
    if (bus.err === 1'b1) err_seen++;
    if (bus.valid === 1'b1 && bus.err === 1'b1) both_seen++;
  endtask

  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    for (int k = 0; k < n; k++) step(d, s);
  endtask

  task automatic digit(input int i, input int v);
    hold(4'(1 << i), seg(v), 3);
  endtask

  task automatic clr_counts();
    valid_seen = 0;
    err_seen   = 0;
  endtask

  initial begin
    bus.dsel  = '0;
    bus.seven = '0;

    // Reset with random inputs
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step(4'($urandom), 7'($urandom));
      chk("rst_bcd", 32'(bus.bcd_out), 32'h0);
      chk("rst_valid", 32'(bus.valid), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
    end
    rst = 1'b0;
    step(4'b0000, 7'b0);
    chk("post_rst_bcd", 32'(bus.bcd_out), 32'h0);
    chk("post_rst_flags", {30'b0, bus.valid, bus.err}, 32'h0);

    // Full frame 4321, valid exactly one cycle after the last 3rd sample
    clr_counts();
    digit(0, 1);
    digit(1, 2);
    digit(2, 3);
    hold(4'b1000, seg(4), 2);
    chk("frame_early_valid", 32'(bus.valid), 32'h0);
    step(4'b1000, seg(4));
    chk("frame_valid", 32'(bus.valid), 32'h1);
    chk("frame_bcd", 32'(bus.bcd_out), 32'h4321);
    step(4'b1000, seg(4));
    chk("frame_valid_drop", 32'(bus.valid), 32'h0);
    step(4'b0000, 7'b0);
    chk("frame_valid_count", 32'(valid_seen), 32'd1);
    chk("frame_err_count", 32'(err_seen), 32'd0);
    chk("frame_bcd_hold", 32'(bus.bcd_out), 32'h4321);

    // Glitch filtering on digit 0
    clr_counts();
    for (int k = 0; k < 6; k++) step(4'b0001, (k % 2 == 0) ? seg(1) : seg(7));
    hold(4'b0001, seg(7), 3);
    digit(1, 2);
    digit(2, 3);
    digit(3, 4);
    chk("glitch_valid", 32'(bus.valid), 32'h1);
    chk("glitch_bcd", 32'(bus.bcd_out), 32'h4327);
    chk("glitch_err_count", 32'(err_seen), 32'd0);
    step(4'b0000, 7'b0);

    // Invalid pattern: one err pulse, no valid
    clr_counts();
    hold(4'b0100, 7'b1110000, 2);
    chk("inv_err_early", 32'(bus.err), 32'h0);
    step(4'b0100, 7'b1110000);
    chk("inv_err", 32'(bus.err), 32'h1);
    hold(4'b0100, 7'b1110000, 2);
    chk("inv_err_count", 32'(err_seen), 32'd1);
    chk("inv_valid_count", 32'(valid_seen), 32'd0);

    // Non-one-hot select: err every cycle
    clr_counts();
    step(4'b0011, seg(1));
    chk("sel_err1", 32'(bus.err), 32'h1);
    step(4'b0011, seg(1));
    chk("sel_err2", 32'(bus.err), 32'h1);
    step(4'b0000, 7'b0);
    chk("sel_err_count", 32'(err_seen), 32'd2);
    chk("sel_valid_count", 32'(valid_seen), 32'd0);

    // Following clean scan completes normally
    clr_counts();
    digit(0, 9);
    digit(1, 8);
    digit(2, 0);
    digit(3, 6);
    chk("recover_valid", 32'(bus.valid), 32'h1);
    chk("recover_bcd", 32'(bus.bcd_out), 32'h6089);
    step(4'b0000, 7'b0);
    chk("recover_err_count", 32'(err_seen), 32'd0);

    // Blank digit 3
    clr_counts();
    digit(0, 5);
    digit(1, 6);
    digit(2, 8);
    hold(4'b1000, 7'b0000000, 3);
`ifdef SEVEN_BCD_BLANK_EN
    chk("blank_valid", 32'(bus.valid), 32'h1);
    chk("blank_bcd", 32'(bus.bcd_out), 32'hF865);
    chk("blank_err_count", 32'(err_seen), 32'd0);
`else
    chk("blank_err", 32'(bus.err), 32'h1);
    chk("blank_valid_count", 32'(valid_seen), 32'd0);
    chk("blank_bcd_hold", 32'(bus.bcd_out), 32'h6089);
`endif
    step(4'b0000, 7'b0);

    // Reset mid-frame discards committed digits
    clr_counts();
    digit(0, 1);
    digit(1, 2);
    digit(2, 3);
    rst = 1'b1;
    step(4'b0000, 7'b0);
    rst = 1'b0;
    chk("midrst_bcd", 32'(bus.bcd_out), 32'h0);
    clr_counts();
    digit(3, 4);
    hold(4'b0000, 7'b0, 2);
    chk("midrst_valid_count", 32'(valid_seen), 32'd0);
    chk("midrst_bcd_after", 32'(bus.bcd_out), 32'h0);

    chk("never_valid_and_err", 32'(both_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
